// File: rtl/rf_pkg.sv
// Shared sizing constants and dump-state encoding for the register file.
package rf_pkg;

  localparam int RF_DEPTH = 32;
  localparam int RF_AW    = 5;
  localparam int RF_DW    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/reg_file_dump.sv
// Dump sequencer: walks every register entry in address order and presents
// each one as a valid/ready beat, then pulses done once the last beat is taken.
// The beat data is captured into a register so later writes cannot disturb it.
module reg_file_dump
  import rf_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             ready_i,
  input  logic [RF_DW-1:0] ld_data_i,
  output logic [RF_AW-1:0] ld_addr_o,
  output logic             valid_o,
  output logic [RF_AW-1:0] addr_o,
  output logic [RF_DW-1:0] data_o,
  output logic             done_o
);

  dump_state_e      state_q, state_d;
  logic [RF_AW-1:0] ptr_q, ptr_d;
  logic [RF_DW-1:0] data_q, data_d;

  // Next-state logic; ld_addr_o names the entry the beat register loads next.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    ld_addr_o = ptr_q + RF_AW'(1);
    case (state_q)
      IDLE: begin
        ld_addr_o = '0;
        if (req_i) begin
          state_d = SCAN;
          ptr_d   = '0;
          data_d  = ld_data_i;
        end
      end
      SCAN: begin
        if (ready_i) begin
          if (ptr_q == RF_AW'(RF_DEPTH - 1)) begin
            state_d = DONE;
          end else begin
            ptr_d  = ptr_q + RF_AW'(1);
            data_d = ld_data_i;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // State, pointer and held beat data; reset aborts any dump in progress.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = (state_q == SCAN);
  assign done_o  = (state_q == DONE);
  assign addr_o  = ptr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/reg_file.sv
// 32 x 8 register file with two combinational read ports, one write port
// sharing the X address, and a streaming dump port.
// Optional feature: define RF_WR_BYPASS_EN to forward DIN to any read port
// whose address matches the write address during a write.
module reg_file
  import rf_pkg::*;
#(
  parameter logic [RF_DW-1:0] RESET_VAL = 8'h00
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [RF_DW-1:0] DIN,
  input  logic [RF_AW-1:0] ADRX,
  input  logic [RF_AW-1:0] ADRY,
  input  logic             RF_WR,
  output logic [RF_DW-1:0] DX_OUT,
  output logic [RF_DW-1:0] DY_OUT,
  input  logic             DUMP_REQ,
  input  logic             DUMP_READY,
  output logic             DUMP_VALID,
  output logic [RF_AW-1:0] DUMP_ADDR,
  output logic [RF_DW-1:0] DUMP_DATA,
  output logic             DUMP_DONE
);

  logic [RF_DW-1:0] mem_q [RF_DEPTH];
  logic [RF_AW-1:0] ld_addr;
  logic [RF_DW-1:0] ld_data;

  // Storage array; reset wins over a simultaneous write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        mem_q[i] <= RESET_VAL;
      end
    end else if (RF_WR) begin
      mem_q[ADRX] <= DIN;
    end
  end

`ifdef RF_WR_BYPASS_EN
  assign DX_OUT = RF_WR ? DIN : mem_q[ADRX];
  assign DY_OUT = (RF_WR && (ADRY == ADRX)) ? DIN : mem_q[ADRY];
`else
  assign DX_OUT = mem_q[ADRX];
  assign DY_OUT = mem_q[ADRY];
`endif

  // A beat loaded on the same edge as a write to that entry takes the new data.
  assign ld_data = (RF_WR && (ADRX == ld_addr)) ? DIN : mem_q[ld_addr];

  reg_file_dump u_dump (
    .clk_i     (CLK),
    .rst_i     (RST),
    .req_i     (DUMP_REQ),
    .ready_i   (DUMP_READY),
    .ld_data_i (ld_data),
    .ld_addr_o (ld_addr),
    .valid_o   (DUMP_VALID),
    .addr_o    (DUMP_ADDR),
    .data_o    (DUMP_DATA),
    .done_o    (DUMP_DONE)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file built with RESET_VAL = 8'h3C.
// The reference model is a plain array updated on each clock; dump beats are
// expected to carry the entry contents as of the edge that made them current.
module tb_reg_file;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic [4:0] adrX = '0;
  logic [4:0] adrY = '0;
  logic       rfWr = 1'b0;
  logic [7:0] dxOut, dyOut;
  logic       dumpReq = 1'b0;
  logic       dumpReady = 1'b0;
  logic       dumpValid;
  logic [4:0] dumpAddr;
  logic [7:0] dumpData;
  logic       dumpDone;

  int total = 0;
  int bad = 0;

  logic [7:0] modelMem [32];

  reg_file #(.RESET_VAL(8'h3C)) dut (
    .CLK        (clk),
    .RST        (rst),
    .DIN        (din),
    .ADRX       (adrX),
    .ADRY       (adrY),
    .RF_WR      (rfWr),
    .DX_OUT     (dxOut),
    .DY_OUT     (dyOut),
    .DUMP_REQ   (dumpReq),
    .DUMP_READY (dumpReady),
    .DUMP_VALID (dumpValid),
    .DUMP_ADDR  (dumpAddr),
    .DUMP_DATA  (dumpData),
    .DUMP_DONE  (dumpDone)
  );

  always #5 clk = ~clk;

  // Reference storage: reset fills every entry, otherwise a write lands on the edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) modelMem[i] <= 8'h3C;
    end else if (rfWr) begin
      modelMem[adrX] <= din;
    end
  end

  function automatic logic [7:0] expRead(input logic [4:0] addr);
`ifdef RF_WR_BYPASS_EN
    if (rfWr && addr == adrX) return din;
`endif
    return modelMem[addr];
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; rfWr = 1'b1; adrX = 5'd3; din = 8'h77; dumpReq = 1'b1;
    @(negedge clk);
    total++;
    if (dumpValid !== 1'b0 || dumpDone !== 1'b0 || dumpAddr !== 5'd0 || dumpData !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_dump_outputs: got valid=%b done=%b addr=%0d data=%h, need 0/0/0/00",
               dumpValid, dumpDone, dumpAddr, dumpData);
    end
    rst = 1'b0; rfWr = 1'b0; dumpReq = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      adrX = 5'(i); adrY = 5'(31 - i);
      #1;
      total++;
      if (dxOut !== 8'h3C || dyOut !== 8'h3C) begin
        bad++;
        $display("[TB] FAIL reset_entry_%0d: got dx=%h dy=%h, need 3c", i, dxOut, dyOut);
      end
    end
  endtask

  task automatic test_write_read();
    logic [7:0] oldVal;
    logic [7:0] expDx;
    @(negedge clk);
    oldVal = modelMem[5];
    rfWr = 1'b1; adrX = 5'd5; adrY = 5'd5; din = 8'hA5;
`ifdef RF_WR_BYPASS_EN
    expDx = 8'hA5;
`else
    expDx = oldVal;
`endif
    #1;
    total++;
    if (dxOut !== expDx || dyOut !== expDx) begin
      bad++;
      $display("[TB] FAIL write_cycle_read: got dx=%h dy=%h, need %h", dxOut, dyOut, expDx);
    end
    @(negedge clk);
    rfWr = 1'b0;
    #1;
    total++;
    if (dxOut !== 8'hA5 || dyOut !== 8'hA5) begin
      bad++;
      $display("[TB] FAIL write_next_read: got dx=%h dy=%h, need a5", dxOut, dyOut);
    end
  endtask

  task automatic test_random_rw();
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      rfWr = 1'($urandom_range(0, 1));
      adrX = 5'($urandom_range(0, 31));
      adrY = ($urandom_range(0, 3) == 0) ? adrX : 5'($urandom_range(0, 31));
      din  = 8'($urandom);
      #1;
      total++;
      if (dxOut !== expRead(adrX) || dyOut !== expRead(adrY)) begin
        bad++;
        $display("[TB] FAIL random_rw_%0d: got dx=%h dy=%h, need dx=%h dy=%h",
                 n, dxOut, dyOut, expRead(adrX), expRead(adrY));
      end
    end
    @(negedge clk);
    rfWr = 1'b0;
  endtask

  task automatic preload();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rfWr = 1'b1; adrX = 5'(i); din = 8'(i + 1);
    end
    @(negedge clk);
    rfWr = 1'b0;
  endtask

  task automatic test_dump(input int stallBeat, input int stallCycles,
                           input bit randWrites, input bit extraReq, input string tag);
    int idx = 0;
    int stalls = 0;
    bit newBeat = 1'b1;
    bit finished = 1'b0;
    logic [7:0] snap = '0;
    @(negedge clk);
    rfWr = 1'b0; dumpReq = 1'b1; dumpReady = 1'b1;
    @(negedge clk);
    dumpReq = 1'b0;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      if (idx < 32) begin
        if (newBeat) begin
          snap = modelMem[idx];
          newBeat = 1'b0;
        end
        total++;
        if (dumpValid !== 1'b1 || dumpAddr !== 5'(idx) || dumpData !== snap || dumpDone !== 1'b0) begin
          bad++;
          $display("[TB] FAIL %s_beat_%0d: got valid=%b addr=%0d data=%h done=%b, need 1/%0d/%h/0",
                   tag, idx, dumpValid, dumpAddr, dumpData, dumpDone, idx, snap);
        end
      end else if (idx == 32) begin
        total++;
        if (dumpDone !== 1'b1 || dumpValid !== 1'b0) begin
          bad++;
          $display("[TB] FAIL %s_done_pulse: got done=%b valid=%b, need 1/0", tag, dumpDone, dumpValid);
        end
        idx = 33;
      end else begin
        total++;
        if (dumpDone !== 1'b0 || dumpValid !== 1'b0) begin
          bad++;
          $display("[TB] FAIL %s_after_done: got done=%b valid=%b, need 0/0", tag, dumpDone, dumpValid);
        end
        finished = 1'b1;
      end
      dumpReady = !(idx == stallBeat && stalls < stallCycles);
      rfWr = 1'b0;
      if (!dumpReady) begin
        stalls++;
        rfWr = 1'b1; adrX = 5'(stallBeat); din = 8'hFF;
      end else if (randWrites && idx < 32) begin
        rfWr = 1'($urandom_range(0, 1));
        adrX = ($urandom_range(0, 1) == 1) ? 5'((idx + 1) % 32) : 5'($urandom_range(0, 31));
        din  = 8'($urandom);
      end
      dumpReq = extraReq && idx < 30 && ($urandom_range(0, 3) == 0);
      @(posedge clk);
      if (idx < 32 && dumpReady) begin
        idx++;
        newBeat = 1'b1;
      end
      @(negedge clk);
    end
    rfWr = 1'b0; dumpReq = 1'b0;
    if (!finished) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: dump did not complete, reached beat %0d", tag, idx);
    end
  endtask

  task automatic test_reset_mid_dump();
    @(negedge clk);
    dumpReq = 1'b1; dumpReady = 1'b1; rfWr = 1'b0;
    @(negedge clk);
    dumpReq = 1'b0;
    repeat (12) @(negedge clk);
    total++;
    if (dumpValid !== 1'b1 || dumpAddr !== 5'd12) begin
      bad++;
      $display("[TB] FAIL abort_reach_beat12: got valid=%b addr=%0d, need 1/12", dumpValid, dumpAddr);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (dumpValid !== 1'b0 || dumpDone !== 1'b0 || dumpAddr !== 5'd0 || dumpData !== 8'h00) begin
      bad++;
      $display("[TB] FAIL abort_immediate: got valid=%b done=%b addr=%0d data=%h, need 0/0/0/00",
               dumpValid, dumpDone, dumpAddr, dumpData);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 1) rst = 1'b0;
      total++;
      if (dumpDone !== 1'b0 || dumpValid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL abort_no_done_%0d: got done=%b valid=%b, need 0/0", k, dumpDone, dumpValid);
      end
    end
    test_dump(99, 0, 1'b0, 1'b0, "restart");
  endtask

  task automatic test_req_during_scan();
    test_dump(99, 0, 1'b1, 1'b1, "ignore_req");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (dumpDone !== 1'b0 || dumpValid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL ignore_req_no_restart_%0d: got done=%b valid=%b, need 0/0", k, dumpDone, dumpValid);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_write_read();
    test_random_rw();
    test_reset();
    preload();
    test_dump(99, 0, 1'b0, 1'b0, "basic");
    test_dump(7, 3, 1'b0, 1'b0, "stall7");
    preload();
    test_dump(99, 0, 1'b1, 1'b0, "randwr");
    test_reset_mid_dump();
    preload();
    test_req_during_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter RESET_VAL, default 8'h00: value every register entry takes on reset.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 DIN  input  8  write data, driven by the register-file write-data select mux output.
REQ-005 ADRX  input  5  read port X address; also the write address.
REQ-006 ADRY  input  5  read port Y address.
REQ-007 RF_WR  input  1  write enable.
REQ-008 DX_OUT  output  8  read port X data.
REQ-009 DY_OUT  output  8  read port Y data.
REQ-010 DUMP_REQ  input  1  start-dump request, sampled in IDLE only.
REQ-011 DUMP_READY  input  1  consumer accepts current dump beat.
REQ-012 DUMP_VALID  output  1  dump beat valid.
REQ-013 DUMP_ADDR  output  5  address of current dump beat.
REQ-014 DUMP_DATA  output  8  data of current dump beat.
REQ-015 DUMP_DONE  output  1  one-cycle pulse after final beat accepted.

Function
REQ-016 Storage shall be 32 entries x 8 bits.
REQ-017 RF_WR=1 at a rising CLK edge shall write DIN into entry ADRX.
REQ-018 DX_OUT/DY_OUT shall be combinational reads of entries ADRX/ADRY, zero latency.
REQ-019 Without bypass, a same-cycle read of the address being written shall return the old value; the new value appears the cycle after the edge.
REQ-020 Dump FSM states: IDLE, SCAN, DONE.
REQ-021 IDLE: DUMP_REQ=1 shall go to SCAN with pointer 0 and load DUMP_DATA from entry 0.
REQ-022 SCAN: DUMP_VALID=1, DUMP_ADDR=pointer; DUMP_ADDR/DUMP_DATA shall be held stable while DUMP_READY=0.
REQ-023 SCAN with DUMP_READY=1 and pointer<31: pointer increments; DUMP_DATA loads the next entry.
REQ-024 SCAN with DUMP_READY=1 and pointer=31: go to DONE; pointer shall not wrap.
REQ-025 DONE: DUMP_DONE=1 for exactly one cycle, DUMP_VALID=0, then IDLE.
REQ-026 DUMP_REQ outside IDLE shall be ignored; no queuing.
REQ-027 Writes shall remain fully functional during a dump.
REQ-028 When DUMP_DATA is loaded in the same cycle that RF_WR targets the entry being loaded, the loaded value shall be DIN.
REQ-029 A write to an entry already dumped or currently held shall not alter the beat in flight.

Reset
REQ-030 RST=1 shall immediately set all 32 entries to RESET_VAL, FSM to IDLE, pointer to 0, DUMP_VALID/DUMP_DONE to 0, DUMP_ADDR/DUMP_DATA to 0.
REQ-031 Reset mid-dump shall abort the dump without a DUMP_DONE pulse.
REQ-032 Writes with RF_WR=1 while RST=1 shall be discarded.

Configuration
REQ-033 Macro RF_WR_BYPASS_EN defined: when RF_WR=1, a read port whose address equals ADRX shall output DIN combinationally in the same cycle.
REQ-034 Macro RF_WR_BYPASS_EN undefined: REQ-019 holds; no bypass logic shall be present.

Structure
REQ-035 Package rf_pkg shall hold RF_DEPTH=32, RF_AW=5, RF_DW=8, and the dump-state enum (IDLE, SCAN, DONE).
REQ-036 The dump FSM and pointer shall be the sub-module reg_file_dump; the storage array and read/write ports shall stay in reg_file.

Verification
REQ-037 Write sequence: RF_WR=1, ADRX=5, DIN=8'hA5, then ADRX=5, ADRY=5 -> DX_OUT=DY_OUT=8'hA5 next cycle; in the write cycle DX_OUT=old value (bypass off) or 8'hA5 (bypass on).
REQ-038 Reset with RESET_VAL=8'h3C after arbitrary writes -> all 32 reads return 8'h3C; dump beat outputs are 0.
REQ-039 Entry i loaded with i+1; DUMP_REQ pulse; DUMP_READY=1 constant -> 32 consecutive beats, addresses 0..31, data 1..32; DUMP_DONE high exactly one cycle after beat 31.
REQ-040 Dump with DUMP_READY=0 for 3 cycles at beat 7 while RF_WR writes 8'hFF to entry 7 -> beat 7 holds the original value across the stall.
REQ-041 RST asserted during beat 12 -> DUMP_VALID=0 immediately; DUMP_DONE never pulses; a new DUMP_REQ restarts at address 0.
REQ-042 DUMP_REQ during SCAN -> ignored; exactly one DUMP_DONE pulse.
